// File: rtl/branch_resolver_pkg.sv
// Shared constants for branch resolution: condition codes, FSM encoding, data width.
// Used by the resolver and by the comparator that sits beside it.
package branch_resolver_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_GE = 3'b001;
  localparam logic [2:0] OP_LE = 3'b010;
  localparam logic [2:0] OP_GT = 3'b011;
  localparam logic [2:0] OP_LT = 3'b100;
  localparam logic [2:0] OP_NE = 3'b101;

  // Codes at or above this value have no defined condition.
  localparam logic [2:0] OP_ILLEGAL_MIN = 3'b110;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEval  = 2'd1,
    StFlush = 2'd2
  } state_e;

  function automatic logic op_is_illegal(input logic [2:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Request, comparator and result signals of the branch resolver.
// slave is the resolver side; master is the pipeline/comparator side.
interface branch_resolver_if #(
  parameter int unsigned CNT_W = 16
);
  import branch_resolver_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_offset;

  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  logic [2:0]        cmp_op;
  logic              cmp_out;

  logic              res_valid;
  logic              res_taken;
  logic              res_illegal;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              flush;
  logic [CNT_W-1:0]  taken_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_pc, in_offset, cmp_out,
    output in_ready, cmp_a, cmp_b, cmp_op, res_valid, res_taken, res_illegal,
           redirect_valid, redirect_pc, flush, taken_cnt
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_pc, in_offset, cmp_out,
    input  in_ready, cmp_a, cmp_b, cmp_op, res_valid, res_taken, res_illegal,
           redirect_valid, redirect_pc, flush, taken_cnt
  );

endinterface

// File: rtl/branch_target_adder.sv
// Branch/jump target: pc + 4 + (word offset << 2), wrapping modulo 2^32.
module branch_target_adder
  import branch_resolver_pkg::*;
(
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] offset,
  output logic [DATA_W-1:0] target
);

  assign target = pc + DATA_W'(4) + (offset << 2);

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: latches a request, evaluates it through the external
// comparator, redirects fetch on a taken branch and then holds flush for FLUSH_CYCLES.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  branch_resolver_if.slave  bus
);

  state_e            state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] offset_q;
  logic [3:0]        flush_cnt_q;
  logic [CNT_W-1:0]  taken_cnt_q;

  logic              in_eval;
  logic              illegal;
  logic              taken;
  logic [DATA_W-1:0] target;

  branch_target_adder u_target (
    .pc     (pc_q),
    .offset (offset_q),
    .target (target)
  );

  assign in_eval = (state_q == StEval);
  assign illegal = op_is_illegal(op_q);
  // Illegal codes never take, whatever the comparator reports.
  assign taken   = in_eval && !illegal && bus.cmp_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      pc_q        <= '0;
      offset_q    <= '0;
      flush_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (taken && (taken_cnt_q != '1)) begin
        taken_cnt_q <= taken_cnt_q + 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q      <= bus.in_a;
            b_q      <= bus.in_b;
            op_q     <= bus.in_op;
            pc_q     <= bus.in_pc;
            offset_q <= bus.in_offset;
            state_q  <= StEval;
          end
        end
        StEval: begin
          if (taken) begin
            flush_cnt_q <= 4'(FLUSH_CYCLES);
            state_q     <= StFlush;
          end else begin
            state_q <= StIdle;
          end
        end
        StFlush: begin
          if (flush_cnt_q == 4'd1) begin
            state_q <= StIdle;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready       = (state_q == StIdle);
  assign bus.flush          = (state_q == StFlush);
  assign bus.cmp_a          = a_q;
  assign bus.cmp_b          = b_q;
  assign bus.cmp_op         = op_q;
  assign bus.res_valid      = in_eval;
  assign bus.res_taken      = taken;
  assign bus.res_illegal    = in_eval && illegal;
  assign bus.redirect_valid = taken;
  assign bus.redirect_pc    = taken ? target : '0;
  assign bus.taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a behavioural unsigned comparator alongside.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned CNT_W        = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  branch_resolver_if #(.CNT_W(CNT_W)) bus ();

  branch_resolver #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Illegal codes report 1 so that ignoring the comparator is actually exercised.
  always_comb begin
    bus.cmp_out = 1'b1;
    case (bus.cmp_op)
      OP_EQ:   bus.cmp_out = (bus.cmp_a == bus.cmp_b);
      OP_GE:   bus.cmp_out = (bus.cmp_a >= bus.cmp_b);
      OP_LE:   bus.cmp_out = (bus.cmp_a <= bus.cmp_b);
      OP_GT:   bus.cmp_out = (bus.cmp_a >  bus.cmp_b);
      OP_LT:   bus.cmp_out = (bus.cmp_a <  bus.cmp_b);
      OP_NE:   bus.cmp_out = (bus.cmp_a != bus.cmp_b);
      default: bus.cmp_out = 1'b1;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request from idle; checks the EVAL cycle and the length of any flush.
  task automatic do_branch(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [31:0] pc,
                           input logic [31:0] off, input logic exp_taken,
                           input logic exp_ill, input logic [31:0] exp_pc);
    int nfl;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.in_pc     = pc;
    bus.in_offset = off;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'hDEAD_BEEF;
    bus.in_b      = 32'h1234_5678;
    bus.in_op     = 3'b011;
    bus.in_pc     = 32'hCAFE_0000;
    @(negedge clk);
    check({tag, ".res_valid"},   bus.res_valid, 1);
    check({tag, ".res_taken"},   bus.res_taken, exp_taken);
    check({tag, ".res_illegal"}, bus.res_illegal, exp_ill);
    check({tag, ".redirect_v"},  bus.redirect_valid, exp_taken);
    if (exp_taken) check({tag, ".redirect_pc"}, bus.redirect_pc, exp_pc);
    check({tag, ".ready_eval"},  bus.in_ready, 0);
    check({tag, ".cmp_a"},       bus.cmp_a, a);
    check({tag, ".cmp_op"},      bus.cmp_op, op);
    nfl = 0;
    @(negedge clk);
    while (bus.flush && nfl < 20) begin
      nfl++;
      @(negedge clk);
    end
    check({tag, ".flush_len"}, nfl, exp_taken ? FLUSH_CYCLES : 0);
    check({tag, ".ready_end"}, bus.in_ready, 1);
  endtask

  logic [2:0] b2b_ops [6];
  logic       b2b_exp [6];

  initial begin
    int nfl;
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.in_pc     = '0;
    bus.in_offset = '0;
    b2b_ops = '{OP_EQ, OP_GE, OP_LE, OP_GT, OP_LT, OP_NE};
    b2b_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    check("rst.in_ready",    bus.in_ready, 1);
    check("rst.cmp_a",       bus.cmp_a, 0);
    check("rst.cmp_op",      bus.cmp_op, 0);
    check("rst.res_valid",   bus.res_valid, 0);
    check("rst.redirect_v",  bus.redirect_valid, 0);
    check("rst.redirect_pc", bus.redirect_pc, 0);
    check("rst.flush",       bus.flush, 0);
    check("rst.taken_cnt",   bus.taken_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_branch("taken", 32'd5, 32'd5, OP_EQ, 32'h100, 32'd3, 1'b1, 1'b0, 32'h110);
    check("taken.cnt", bus.taken_cnt, 1);
    do_branch("nt_lt", 32'hFFFF_FFFF, 32'd1, OP_LT, 32'h200, 32'd8, 1'b0, 1'b0, 32'h0);
    do_branch("illegal", 32'd0, 32'd0, 3'b111, 32'h300, 32'd1, 1'b0, 1'b1, 32'h0);
    check("illegal.cnt", bus.taken_cnt, 1);
    do_branch("wrap_hi", 32'd1, 32'd1, OP_EQ, 32'hFFFF_FFF8, 32'd1, 1'b1, 1'b0, 32'h0);
    do_branch("wrap_neg", 32'd1, 32'd1, OP_EQ, 32'h10, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hC);
    check("wrap.cnt_sat", bus.taken_cnt, 3);

    // Back-to-back with in_valid held high; inputs scrambled between accepts.
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h400;
    bus.in_offset = 32'd0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b%0d.ready", i), bus.in_ready, 1);
      bus.in_a  = 32'd7;
      bus.in_b  = 32'd3;
      bus.in_op = b2b_ops[i];
      @(posedge clk); #1;
      bus.in_a  = 32'h55;
      bus.in_op = 3'b110;
      @(negedge clk);
      check($sformatf("b2b%0d.res_valid", i), bus.res_valid, 1);
      check($sformatf("b2b%0d.res_taken", i), bus.res_taken, b2b_exp[i]);
      check($sformatf("b2b%0d.cmp_a", i), bus.cmp_a, 7);
      check($sformatf("b2b%0d.ready_eval", i), bus.in_ready, 0);
      nfl = 0;
      @(negedge clk);
      while (!bus.in_ready && nfl < 20) begin
        nfl++;
        check($sformatf("b2b%0d.flush", i), bus.flush, 1);
        check($sformatf("b2b%0d.cmp_hold", i), bus.cmp_op, b2b_ops[i]);
        @(negedge clk);
      end
      check($sformatf("b2b%0d.busy_len", i), nfl, b2b_exp[i] ? FLUSH_CYCLES : 0);
    end
    bus.in_valid = 1'b0;
    check("b2b.cnt_sat", bus.taken_cnt, 3);

    // Reset while flushing must abort at once.
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'd9;
    bus.in_b      = 32'd9;
    bus.in_op     = OP_EQ;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid.flush_before", bus.flush, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.flush",     bus.flush, 0);
    check("rstmid.in_ready",  bus.in_ready, 1);
    check("rstmid.taken_cnt", bus.taken_cnt, 0);
    check("rstmid.redirect",  bus.redirect_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid.flush_after", bus.flush, 0);
    check("rstmid.ready_after", bus.in_ready, 1);

    // Saturation of the 2-bit counter: 1,2,3,3,3.
    for (int i = 0; i < 5; i++) begin
      do_branch($sformatf("sat%0d", i), 32'd2, 32'd1, OP_GT, 32'h40, 32'd4, 1'b1, 1'b0,
                32'h54);
      check($sformatf("sat%0d.cnt", i), bus.taken_cnt, (i < 3) ? i + 1 : 3);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
